instr_encoder: RTL
==================

# instr_encoder

Streams structured instruction descriptors into 32-bit machine words in the processor's own format and writes them, in order, to instruction memory. It is the encoding counterpart of the core's instruction decode. It sits between the debug/program-load front end and the instruction-memory write port. Descriptors are buffered in a small FIFO so that the producer and the memory write port may stall independently.

## Interface
Parameters:
- AW, 6: instruction-memory word-address width.
- DEPTH, 4: FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  descriptor present.
- in_ready  out  1  descriptor accepted when in_valid & in_ready.
- in_class  in  2  00 data-processing, 01 memory, 10 branch, 11 illegal.
- in_cmd  in  4  ALU command: ADD 0000, SUB 0001, MUL 0010, CMP 0100, AND 1000, ORR 1001, PRM 1010, ACM 1011.
- in_imm  in  1  data-processing operand 2 is an immediate.
- in_s  in  1  set-flags bit.
- in_load  in  1  memory access: 1 = LDR, 0 = STR.
- in_cond  in  4  condition field.
- in_rd, in_rn  in  4 each  register fields.
- in_op2  in  24  [11:0] operand2/offset; [23:0] branch offset.
- base_load  in  1  load the write address.
- base_addr  in  AW  new write address.
- wr_valid  out  1  word presented to instruction memory.
- wr_ready  in  1  memory accepts the word.
- wr_addr  out  AW  word address.
- wr_data  out  32  encoded word.
- done  out  1  one-cycle pulse when the FIFO drains to empty.
- err  out  1  sticky illegal-descriptor flag.
- err_clr  in  1  clears err.

## Operation
- Encoding is combinational from the descriptor; the encoded word is pushed into the FIFO on acceptance.
- Data-processing: {cond, 00, I, cmd, S, rn, rd, op2[11:0]}. S is forced to 1 when cmd is CMP.
- Memory: {cond, 01, 0, 1, 1, 0, 0, L, rn, rd, op2[11:0]}.
- Branch: {cond, 10, 10, op2[23:0]}.
- The FIFO head drives wr_data. wr_data is valid whenever wr_valid is high.
- On wr_valid & wr_ready:
  - the FIFO pops;
  - wr_addr increments modulo 2^AW, so 2^AW−1 wraps to 0 silently.
- in_ready is high when the FIFO is not full. A push into a full FIFO is not accepted, even if a pop occurs in the same cycle.
- A simultaneous push and pop with the FIFO neither empty nor full leaves the level unchanged.
- FSM:
  - IDLE: FIFO empty. Moves to BUSY on acceptance.
  - BUSY: moves to IDLE when the last word pops and there is no push in that cycle; done pulses on that transition.
- base_load is honoured only in IDLE with in_valid low. It is ignored at all other times.

## Timing
- Reset values: in_ready 0 while reset is asserted and 1 from the first edge after release; wr_valid 0, wr_addr 0, wr_data 0, done 0, err 0; FIFO empty; FSM in IDLE.
- Latency: a descriptor accepted at edge N gives wr_valid high after edge N, with the word on wr_data.
- wr_valid and wr_data are held stable until wr_ready is sampled high.
- Reset asserted mid-stream discards all FIFO contents immediately; no partial write is issued.
- err_clr and a new error in the same cycle: err stays set.

## Configuration
- INSTR_ENCODER_CHECK_EN defined:
  - The following are illegal: class 11, and data-processing cmd values outside the listed set.
  - An illegal descriptor is accepted through the handshake but not pushed. err is set, and wr_addr does not advance.
- Undefined:
  - No checking is done; err is tied to 0.
  - Class 11 encodes with the data-processing layout and 11 in bits [27:26].
  - Unlisted cmd values are encoded verbatim.

## Test plan
- Reset, then one descriptor {DP, ADD, imm, S=0, cond E, rn 2, rd 1, op2 0x005} with wr_ready high -> one cycle later, wr_data 0xE2021005 at wr_addr 0; done pulses when it pops.
- LDR rn 4, rd 3, offset 8 followed by the same as STR -> 0xE5943008 at address 0, then 0xE5843008 at address 1.
- Branch cond E, op2 0x000002 -> 0xEA000002. CMP register form rn 2, rm 3, in_s 0 -> 0xE0920003 (S forced).
- wr_ready low while 5 descriptors are offered with DEPTH 4 -> in_ready falls after 4 accepts. Release wr_ready -> words drain in order; the 5th is accepted on the first free slot.
- base_load with base_addr 63 while idle, then two descriptors -> written at addresses 63 and 0. base_load while BUSY -> ignored.
- With INSTR_ENCODER_CHECK_EN, class 11 -> err 1, no write, wr_addr unchanged; err_clr -> err 0.

Source files
------------

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Encodes structured instruction descriptors into 32-bit machine words in the
// processor's native format. It buffers them in a small FIFO and writes them,
// in order, to the instruction-memory write port. The write address is a
// running counter. It can be reloaded only while the encoder is idle.
//
// Optional build macro: INSTR_ENCODER_CHECK_EN
//   defined   - class 11 and unlisted data-processing commands are illegal.
//               They complete the handshake but are dropped, and they set the
//               sticky err flag. err_clr clears err, but a new error in the
//               same cycle wins.
//   undefined - no checking. err is tied low. Class 11 uses the
//               data-processing layout with 11 in bits [27:26].
//
// Parameters
//   AW    - instruction-memory word-address width
//   DEPTH - FIFO entries (power of two, >= 2)
//
// Ports
//   clk, reset            - clock, asynchronous active-high reset
//   in_valid / in_ready   - descriptor handshake
//   in_class, in_cmd, in_imm, in_s, in_load, in_cond, in_rd, in_rn, in_op2
//                         - descriptor fields
//   base_load, base_addr  - reload write address (idle, no descriptor offered)
//   wr_valid / wr_ready   - instruction-memory write handshake
//   wr_addr, wr_data      - word address and encoded word (FIFO head)
//   done                  - one-cycle pulse when the FIFO drains to empty
//   err, err_clr          - sticky illegal-descriptor flag and its clear
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int AW    = 6,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_class,
  input  logic [3:0]    in_cmd,
  input  logic          in_imm,
  input  logic          in_s,
  input  logic          in_load,
  input  logic [3:0]    in_cond,
  input  logic [3:0]    in_rd,
  input  logic [3:0]    in_rn,
  input  logic [23:0]   in_op2,
  input  logic          base_load,
  input  logic [AW-1:0] base_addr,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          done,
  output logic          err,
  input  logic          err_clr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE_LVL  = (PW+1)'(1);
  localparam logic [3:0]  CMD_CMP  = 4'b0100;

  typedef enum logic {IDLE, BUSY} state_t;

  // Encoding: one layout per instruction class.
  function automatic logic [31:0] encode_word(
    input logic [1:0]  cls,
    input logic [3:0]  cmd,
    input logic        imm,
    input logic        s,
    input logic        load,
    input logic [3:0]  cond,
    input logic [3:0]  rd,
    input logic [3:0]  rn,
    input logic [23:0] op2
  );
    logic s_eff;
    logic [31:0] w;
    // CMP only exists to set flags, so S is forced on.
    s_eff = s | (cmd == CMD_CMP);
    case (cls)
      2'b00:   w = {cond, 2'b00, imm, cmd, s_eff, rn, rd, op2[11:0]};
      2'b01:   w = {cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, load, rn, rd, op2[11:0]};
      2'b10:   w = {cond, 2'b10, 2'b10, op2};
      default: w = {cond, 2'b11, imm, cmd, s_eff, rn, rd, op2[11:0]};
    endcase
    return w;
  endfunction

`ifdef INSTR_ENCODER_CHECK_EN
  function automatic logic cmd_listed(input logic [3:0] cmd);
    logic ok;
    case (cmd)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b1001, 4'b1010, 4'b1011: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction
`endif

  // State
  logic [31:0]   fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q,  count_d;
  logic [AW-1:0] addr_q,   addr_d;
  logic          err_q,    err_d;
  logic          rdy_q;
  logic          done_q;
  state_t        state_q;

  // Handshake decode
  logic        full, empty, accept, illegal, push, pop;
  logic [31:0] enc_word;

  assign full  = (count_q == FULL_LVL);
  assign empty = (count_q == '0);

  // rdy_q keeps in_ready low during reset and for the release edge itself.
  assign in_ready = rdy_q & ~full;
  assign accept   = in_valid & in_ready;
  assign pop      = ~empty & wr_ready;

`ifdef INSTR_ENCODER_CHECK_EN
  assign illegal = (in_class == 2'b11) |
                   ((in_class == 2'b00) & ~cmd_listed(in_cmd));
`else
  assign illegal = 1'b0;
`endif

  // Illegal descriptors complete the handshake but never enter the FIFO.
  assign push = accept & ~illegal;

  assign enc_word = encode_word(in_class, in_cmd, in_imm, in_s, in_load,
                                in_cond, in_rd, in_rn, in_op2);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // The address advances modulo 2^AW. A reload is possible only when idle,
    // so it can never coincide with a pop.
    if (pop)
      addr_d = addr_q + 1'b1;
    else if ((state_q == IDLE) && !in_valid && base_load)
      addr_d = base_addr;
  end

`ifdef INSTR_ENCODER_CHECK_EN
  always_comb begin
    err_d = (err_q & ~err_clr) | (accept & illegal);
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  always_comb begin
    err_d = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      rdy_q    <= 1'b1;
    end
  end

  // FIFO storage. Contents are meaningful only below count_q, so storage
  // needs no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= enc_word;
  end

  // Control FSM. done is registered, so it rises together with the empty FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (push) state_q <= BUSY;
        BUSY: if (pop && (count_q == ONE_LVL) && !push) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_valid = ~empty;
  assign wr_data  = empty ? 32'h0 : fifo_mem[rd_ptr_q];
  assign wr_addr  = addr_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
